// File: rtl/bridge_responder.sv
// Device-side endpoint of the KMBox bridge UART protocol: parses SYNC/CMD/payload
// packets into HID event strobes and answers with fixed 8-byte ACK/NACK/PONG frames.
module bridge_responder #(
  parameter int          CLK_FREQ       = 48_000_000,
  parameter int          TIMEOUT_CLKS   = CLK_FREQ / 1000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
  parameter logic [7:0]  CMD_MOVE       = 8'h01,
  parameter logic [7:0]  CMD_WHEEL      = 8'h02,
  parameter logic [7:0]  CMD_BTN        = 8'h03,
  parameter logic [7:0]  CMD_MOVE_WHEEL = 8'h04,
  parameter logic [7:0]  CMD_PING       = 8'h05,
  parameter logic [7:0]  CMD_RESET      = 8'h06,
  parameter logic [7:0]  HDR_ACK        = 8'h0C,
  parameter logic [7:0]  HDR_NACK       = 8'h0E,
  parameter logic [7:0]  HDR_PONG       = 8'hA0,
  parameter bit          ACK_EN         = 1'b1,
  parameter logic [7:0]  VERSION        = 8'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        evt_move,
  output logic [15:0] evt_dx,
  output logic [15:0] evt_dy,
  output logic        evt_wheel,
  output logic [7:0]  evt_wheel_val,
  output logic [7:0]  btn_state,
  output logic        evt_btn,
  output logic        evt_reset,
  output logic [15:0] pkt_count,
  output logic [15:0] err_count,
  output logic [7:0]  drop_count,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [1:0] {P_SYNC, P_CMD, P_PAYLOAD} p_state_t;
  typedef enum logic {R_IDLE, R_SEND} r_state_t;

  // Handshake: a response byte transfers on any cycle where tx_valid && tx_ready;
  // tx_valid and tx_data are held unchanged until that happens.

  p_state_t        p_state, p_next;
  r_state_t        r_state, r_next;
  logic [7:0]      cmd_r;
  logic [2:0]      pay_len;
  logic [2:0]      pay_idx;
  logic [7:0]      pay [0:4];
  logic [7:0]      pl  [0:4];
  logic [TW-1:0]   to_cnt;

  logic [2:0]      cmd_len;
  logic            cmd_known;
  logic            timeout;
  logic            bad_cmd;
  logic            done;
  logic [7:0]      done_cmd;

  logic            q_valid;
  logic [7:0]      q_hdr;
  logic [7:0]      q_cmd;

  logic            slot_full;
  logic [7:0]      slot_hdr;
  logic [7:0]      slot_cmd;
  logic            take;
  logic            accept;
  logic [2:0]      tx_idx;
  logic [7:0]      snap [0:7];

  // Parser next-state and decode.
  always_comb begin
    p_next    = p_state;
    cmd_len   = 3'd0;
    cmd_known = 1'b1;
    timeout   = 1'b0;
    bad_cmd   = 1'b0;
    done      = 1'b0;
    done_cmd  = cmd_r;
    for (int i = 0; i < 5; i++) begin
      pl[i] = pay[i];
      if (pay_idx == 3'(i)) pl[i] = rx_data;
    end

    case (rx_data)
      CMD_MOVE:       cmd_len = 3'd4;
      CMD_WHEEL:      cmd_len = 3'd1;
      CMD_BTN:        cmd_len = 3'd2;
      CMD_MOVE_WHEEL: cmd_len = 3'd5;
      CMD_PING:       cmd_len = 3'd0;
      CMD_RESET:      cmd_len = 3'd0;
      default:        cmd_known = 1'b0;
    endcase

    // An arriving byte always takes priority over the idle timeout.
    if (p_state != P_SYNC && !rx_valid && to_cnt == TW'(TIMEOUT_CLKS - 1)) begin
      timeout = 1'b1;
      p_next  = P_SYNC;
    end

    if (rx_valid) begin
      case (p_state)
        P_SYNC: begin
          if (rx_data == SYNC_BYTE) p_next = P_CMD;
        end
        P_CMD: begin
          if (!cmd_known) begin
            bad_cmd = 1'b1;
            p_next  = P_SYNC;
          end else if (cmd_len == 3'd0) begin
            done     = 1'b1;
            done_cmd = rx_data;
            p_next   = P_SYNC;
          end else begin
            p_next = P_PAYLOAD;
          end
        end
        P_PAYLOAD: begin
          if (pay_idx == pay_len - 3'd1) begin
            done   = 1'b1;
            p_next = P_SYNC;
          end
        end
        default: p_next = P_SYNC;
      endcase
    end
  end

  always_comb begin
    q_valid = bad_cmd || (done && (done_cmd == CMD_PING || ACK_EN));
    q_hdr   = HDR_ACK;
    q_cmd   = done_cmd;
    if (bad_cmd) begin
      q_hdr = HDR_NACK;
      q_cmd = rx_data;
    end else if (done_cmd == CMD_PING) begin
      q_hdr = HDR_PONG;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state       <= P_SYNC;
      cmd_r         <= 8'h00;
      pay_len       <= 3'd0;
      pay_idx       <= 3'd0;
      to_cnt        <= '0;
      for (int i = 0; i < 5; i++) pay[i] <= 8'h00;
      evt_move      <= 1'b0;
      evt_wheel     <= 1'b0;
      evt_btn       <= 1'b0;
      evt_reset     <= 1'b0;
      evt_dx        <= 16'h0000;
      evt_dy        <= 16'h0000;
      evt_wheel_val <= 8'h00;
      btn_state     <= 8'h00;
      pkt_count     <= 16'h0000;
      err_count     <= 16'h0000;
    end else begin
      p_state   <= p_next;
      evt_move  <= 1'b0;
      evt_wheel <= 1'b0;
      evt_btn   <= 1'b0;
      evt_reset <= 1'b0;

      if (p_next == P_SYNC || rx_valid) to_cnt <= '0;
      else                              to_cnt <= to_cnt + 1'b1;

      if (rx_valid && p_state == P_CMD && cmd_known) begin
        cmd_r   <= rx_data;
        pay_len <= cmd_len;
        pay_idx <= 3'd0;
      end
      if (rx_valid && p_state == P_PAYLOAD) begin
        for (int i = 0; i < 5; i++) pay[i] <= pl[i];
        pay_idx <= pay_idx + 3'd1;
      end

      if (bad_cmd || timeout) err_count <= err_count + 16'd1;

      if (done) begin
        pkt_count <= pkt_count + 16'd1;
        case (done_cmd)
          CMD_MOVE: begin
            evt_move <= 1'b1;
            evt_dx   <= {pl[1], pl[0]};
            evt_dy   <= {pl[3], pl[2]};
          end
          CMD_WHEEL: begin
            evt_wheel     <= 1'b1;
            evt_wheel_val <= pl[0];
          end
          CMD_MOVE_WHEEL: begin
            evt_move      <= 1'b1;
            evt_wheel     <= 1'b1;
            evt_dx        <= {pl[1], pl[0]};
            evt_dy        <= {pl[3], pl[2]};
            evt_wheel_val <= pl[4];
          end
          CMD_BTN: begin
            btn_state <= (btn_state & ~pl[0]) | (pl[1] & pl[0]);
            evt_btn   <= 1'b1;
          end
          CMD_RESET: begin
            btn_state <= 8'h00;
            evt_btn   <= 1'b1;
            evt_reset <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Response FSM: a full slot is taken only from R_IDLE.
  always_comb begin
    r_next   = r_state;
    take     = (r_state == R_IDLE) && slot_full;
    accept   = (r_state == R_SEND) && tx_ready;
    tx_valid = (r_state == R_SEND);
    tx_data  = snap[tx_idx];
    busy     = (p_state != P_SYNC) || slot_full || (r_state != R_IDLE);
    case (r_state)
      R_IDLE:  if (slot_full) r_next = R_SEND;
      R_SEND:  if (accept && tx_idx == 3'd7) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_full  <= 1'b0;
      slot_hdr   <= 8'h00;
      slot_cmd   <= 8'h00;
      drop_count <= 8'h00;
    end else begin
      if (q_valid) begin
        slot_full <= 1'b1;
        slot_hdr  <= q_hdr;
        slot_cmd  <= q_cmd;
        if (slot_full && !take && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end else if (take) begin
        slot_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      tx_idx  <= 3'd0;
      for (int i = 0; i < 8; i++) snap[i] <= 8'h00;
    end else begin
      r_state <= r_next;
      if (take) begin
        tx_idx  <= 3'd0;
        snap[0] <= slot_hdr;
        snap[1] <= slot_cmd;
        snap[2] <= btn_state;
        snap[3] <= pkt_count[7:0];
        snap[4] <= pkt_count[15:8];
        snap[5] <= err_count[7:0];
        snap[6] <= err_count[15:8];
        snap[7] <= VERSION;
      end else if (accept) begin
        tx_idx <= tx_idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_bridge_responder.sv
// Bench for bridge_responder: directed protocol scenarios plus randomized packet
// traffic, checked every cycle against a packet-level queue model.
module tb_bridge_responder;

  localparam int         T   = 40;
  localparam logic [7:0] VER = 8'h01;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        evt_move;
  logic [15:0] evt_dx;
  logic [15:0] evt_dy;
  logic        evt_wheel;
  logic [7:0]  evt_wheel_val;
  logic [7:0]  btn_state;
  logic        evt_btn;
  logic        evt_reset;
  logic [15:0] pkt_count;
  logic [15:0] err_count;
  logic [7:0]  drop_count;
  logic        busy;

  bridge_responder #(.CLK_FREQ(48_000_000), .TIMEOUT_CLKS(T)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .evt_move(evt_move), .evt_dx(evt_dx), .evt_dy(evt_dy),
    .evt_wheel(evt_wheel), .evt_wheel_val(evt_wheel_val),
    .btn_state(btn_state), .evt_btn(evt_btn), .evt_reset(evt_reset),
    .pkt_count(pkt_count), .err_count(err_count), .drop_count(drop_count),
    .busy(busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  cur[$];
  logic [7:0]  out_q[$];
  int          idle_cnt;
  logic [7:0]  m_btn, m_drop, m_wv;
  logic [15:0] m_pkt, m_err, m_dx, m_dy;
  bit          m_mv, m_wh, m_bt, m_rs;
  bit          slot_v;
  logic [7:0]  slot_h, slot_c;

  function automatic int plen(input logic [7:0] c);
    case (c)
      8'h01: return 4;
      8'h02: return 1;
      8'h03: return 2;
      8'h04: return 5;
      8'h05: return 0;
      8'h06: return 0;
      default: return -1;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit         take, q;
    logic [7:0] qh, qc, c;
    if (!rst_n) begin
      cur.delete(); out_q.delete();
      idle_cnt = 0; m_btn = 0; m_drop = 0; m_wv = 0;
      m_pkt = 0; m_err = 0; m_dx = 0; m_dy = 0;
      m_mv = 0; m_wh = 0; m_bt = 0; m_rs = 0;
      slot_v = 0; slot_h = 0; slot_c = 0;
    end else begin
      m_mv = 0; m_wh = 0; m_bt = 0; m_rs = 0;
      q = 0; qh = 0; qc = 0;
      take = slot_v && (out_q.size() == 0);
      if (out_q.size() > 0 && tx_ready) void'(out_q.pop_front());
      if (take) begin
        out_q.push_back(slot_h);       out_q.push_back(slot_c);
        out_q.push_back(m_btn);
        out_q.push_back(m_pkt[7:0]);   out_q.push_back(m_pkt[15:8]);
        out_q.push_back(m_err[7:0]);   out_q.push_back(m_err[15:8]);
        out_q.push_back(VER);
        slot_v = 0;
      end
      if (rx_valid) begin
        idle_cnt = 0;
        if (cur.size() == 0) begin
          if (rx_data == 8'hAA) cur.push_back(rx_data);
        end else begin
          cur.push_back(rx_data);
          if (cur.size() == 2 && plen(rx_data) < 0) begin
            m_err++; q = 1; qh = 8'h0E; qc = rx_data;
            cur.delete();
          end else if (cur.size() == plen(cur[1]) + 2) begin
            c = cur[1];
            m_pkt++;
            case (c)
              8'h01: begin m_mv = 1; m_dx = {cur[3], cur[2]}; m_dy = {cur[5], cur[4]}; end
              8'h02: begin m_wh = 1; m_wv = cur[2]; end
              8'h03: begin m_btn = (m_btn & ~cur[2]) | (cur[3] & cur[2]); m_bt = 1; end
              8'h04: begin
                m_mv = 1; m_wh = 1;
                m_dx = {cur[3], cur[2]}; m_dy = {cur[5], cur[4]}; m_wv = cur[6];
              end
              8'h06: begin m_btn = 0; m_rs = 1; m_bt = 1; end
              default: ;
            endcase
            q = 1; qc = c; qh = (c == 8'h05) ? 8'hA0 : 8'h0C;
            cur.delete();
          end
        end
      end else if (cur.size() > 0) begin
        idle_cnt++;
        if (idle_cnt == T) begin
          cur.delete(); m_err++; idle_cnt = 0;
        end
      end
      if (q) begin
        if (slot_v && m_drop != 8'hFF) m_drop++;
        slot_v = 1; slot_h = qh; slot_c = qc;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("evt_move", evt_move, m_mv);
      chk("evt_wheel", evt_wheel, m_wh);
      chk("evt_btn", evt_btn, m_bt);
      chk("evt_reset", evt_reset, m_rs);
      chk("evt_dx", evt_dx, m_dx);
      chk("evt_dy", evt_dy, m_dy);
      chk("evt_wheel_val", evt_wheel_val, m_wv);
      chk("btn_state", btn_state, m_btn);
      chk("pkt_count", pkt_count, m_pkt);
      chk("err_count", err_count, m_err);
      chk("drop_count", drop_count, m_drop);
      chk("busy", busy, (cur.size() > 0) || slot_v || (out_q.size() > 0));
      chk("tx_valid", tx_valid, out_q.size() > 0);
      if (out_q.size() > 0) chk("tx_data", tx_data, out_q[0]);
    end
  end

  logic [7:0] log_q[$];
  int         btn_pulses = 0;
  always @(posedge clk) if (rst_n && tx_valid && tx_ready) log_q.push_back(tx_data);
  always @(negedge clk) if (rst_n && evt_btn) btn_pulses++;

  // ---------------- drivers ----------------
  int rdy_mode = 0;
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = 1'b0;
        2:       tx_ready = ~tx_ready;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    idle(gap);
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i], 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    log_q.delete();
    btn_pulses = 0;
    idle(1);
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((busy || out_q.size() > 0 || slot_v) && k < 2000) begin
      @(posedge clk); #1; k++;
    end
    chk("drain_timeout", (k >= 2000) ? 1 : 0, 0);
    idle(2);
  endtask

  task automatic chk_log(input string name, input logic [7:0] e[$]);
    chk({name, "_len"}, log_q.size(), e.size());
    foreach (e[i]) if (i < log_q.size()) chk(name, log_q[i], e[i]);
  endtask

  task automatic rand_packet();
    logic [7:0] s[$];
    logic [7:0] c;
    int sel, n, cut;
    if ($urandom_range(0, 9) == 0) send_byte(8'($urandom_range(0, 8'hA9)), $urandom_range(0, 2));
    sel = $urandom_range(0, 9);
    if (sel <= 5)      c = 8'(sel + 1);
    else if (sel == 6) c = 8'($urandom_range(7, 255));
    else if (sel == 7) c = 8'h01;
    else if (sel == 8) c = 8'h03;
    else               c = 8'h04;
    s.push_back(8'hAA);
    s.push_back(c);
    n = plen(c);
    for (int i = 0; i < n; i++) s.push_back(8'($urandom_range(0, 255)));
    cut = s.size();
    if ($urandom_range(0, 14) == 0) cut = $urandom_range(1, s.size() - 1);
    for (int i = 0; i < cut; i++) send_byte(s[i], $urandom_range(0, 3));
    if (cut < s.size()) idle(T + 2);
    else idle($urandom_range(0, 4));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    idle(3);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_btn_state", btn_state, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(2);

    // MOVE with the UART always ready
    send_seq('{8'hAA, 8'h01, 8'h34, 8'h12, 8'hCC, 8'hFF});
    wait_drain();
    chk("move_dx", evt_dx, 16'h1234);
    chk("move_dy", evt_dy, 16'hFFCC);
    chk_log("move_resp", '{8'h0C, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01});
    do_reset();

    // button mask/state merge
    send_seq('{8'hAA, 8'h03, 8'h05, 8'h05});
    wait_drain();
    chk("btn_first", btn_state, 8'h05);
    send_seq('{8'hAA, 8'h03, 8'h01, 8'h00});
    wait_drain();
    chk("btn_second", btn_state, 8'h04);
    chk("btn_pulses", btn_pulses, 2);
    chk("btn_err", err_count, 0);
    do_reset();

    // PING with tx_ready toggling
    rdy_mode = 2;
    send_seq('{8'hAA, 8'h05});
    wait_drain();
    chk_log("pong_resp", '{8'hA0, 8'h05, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01});
    rdy_mode = 0;
    do_reset();

    // unknown command then wheel
    send_seq('{8'hAA, 8'h7F});
    wait_drain();
    chk("nack_err", err_count, 1);
    chk("nack_pkt", pkt_count, 0);
    chk_log("nack_resp", '{8'h0E, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01});
    send_seq('{8'hAA, 8'h02, 8'hFB});
    wait_drain();
    chk("wheel_val", evt_wheel_val, 8'hFB);
    do_reset();

    // truncated packet aborted by timeout
    send_seq('{8'hAA, 8'h01, 8'h34});
    idle(T + 3);
    chk("trunc_err", err_count, 1);
    chk("trunc_busy", busy, 0);
    send_seq('{8'hAA, 8'h05});
    wait_drain();
    chk_log("trunc_pong", '{8'hA0, 8'h05, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01});
    do_reset();

    // slot overwrite while the UART is stalled
    rdy_mode = 1;
    idle(1);
    send_seq('{8'hAA, 8'h05, 8'hAA, 8'h05, 8'hAA, 8'h05});
    idle(4);
    chk("ovw_drop", drop_count, 1);
    rdy_mode = 0;
    wait_drain();
    chk("ovw_len", log_q.size(), 16);
    if (log_q.size() == 16) begin
      chk("ovw_hdr0", log_q[0], 8'hA0);
      chk("ovw_pkt0", log_q[3], 8'h01);
      chk("ovw_hdr1", log_q[8], 8'hA0);
      chk("ovw_pkt1", log_q[11], 8'h03);
    end

    // reset in the middle of a response
    send_seq('{8'hAA, 8'h05});
    idle(4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_pkt", pkt_count, 0);
    chk("mid_rst_drop", drop_count, 0);
    chk("mid_rst_busy", busy, 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // randomized traffic with a random-ready UART
    rdy_mode = 3;
    repeat (150) rand_packet();
    rdy_mode = 0;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/bridge_responder.md
Name: bridge_responder

Overview:
- Device-side endpoint of the KMBox bridge UART protocol.
- Parses the bridge command packets produced by bridge_engine: SYNC, CMD, then a CMD-dependent payload.
- Decodes each valid packet into one-cycle event strobes for the HID injection logic.
- Returns fixed 8-byte binary responses (ACK/NACK/PONG) over the UART TX byte interface.
- Sits between uart_rx/uart_tx and the mouse-report merge logic on the KMBox FPGA.

Parameters:
- CLK_FREQ, 48_000_000, clock frequency in Hz.
- TIMEOUT_CLKS, CLK_FREQ/1000, idle cycles inside a packet before it is aborted.
- SYNC_BYTE, 8'hAA, packet start marker.
- CMD_MOVE / CMD_WHEEL / CMD_BTN / CMD_MOVE_WHEEL / CMD_PING / CMD_RESET, 8'h01..8'h06, command codes.
- HDR_ACK / HDR_NACK / HDR_PONG, 8'h0C / 8'h0E / 8'hA0, response header bytes.
- ACK_EN, 1, 1 = ACK every valid non-PING command; 0 = only PONG and NACK are sent.
- VERSION, 8'h01, reported in response byte 7.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  response byte
- tx_valid  out  1  response byte valid, held until accepted
- tx_ready  in  1  UART TX accepts byte when tx_valid && tx_ready
- evt_move  out  1  pulse, evt_dx/evt_dy valid
- evt_dx, evt_dy  out  16 each  signed movement
- evt_wheel  out  1  pulse, evt_wheel_val valid
- evt_wheel_val  out  8  signed wheel delta
- btn_state  out  8  current button state (level)
- evt_btn  out  1  pulse, btn_state just updated
- evt_reset  out  1  pulse on CMD_RESET
- pkt_count  out  16  valid packets received, wraps
- err_count  out  16  protocol errors, wraps
- drop_count  out  8  responses overwritten before being sent, saturates at 8'hFF
- busy  out  1  parser not in P_SYNC, or response pending/sending

Behaviour:
- Reset: every output and counter is 0, tx_valid = 0, parser in P_SYNC, response FSM in R_IDLE, pending slot empty. Reset asserted mid-packet or mid-response aborts it immediately.
- Parser states: P_SYNC, P_CMD, P_PAYLOAD.
  - P_SYNC: a byte equal to SYNC_BYTE goes to P_CMD; any other byte is discarded silently.
  - P_CMD, known cmd: latch cmd, set the payload length (MOVE 4, WHEEL 1, BTN 2, MOVE_WHEEL 5, PING 0, RESET 0).
  - P_CMD, length 0: complete immediately; otherwise go to P_PAYLOAD.
  - P_CMD, unknown cmd: err_count+1, queue NACK echoing that cmd, return to P_SYNC.
- Payload rules:
  - Bytes are stored in arrival order; no escaping, so a payload byte equal to SYNC_BYTE is data.
  - Multi-byte fields are little-endian: x lo, x hi, y lo, y hi, then wheel.
  - BTN payload is mask, then state.
- Completion: the cycle after the rx_valid of the final byte, all of the following happen together:
  - pkt_count+1, parser returns to P_SYNC.
  - The matching strobe is high for exactly 1 cycle:
    - MOVE: evt_move.
    - WHEEL: evt_wheel.
    - MOVE_WHEEL: evt_move and evt_wheel in the same cycle.
    - BTN: btn_state <= (btn_state & ~mask) | (state & mask), then evt_btn.
    - RESET: btn_state <= 0, evt_reset and evt_btn.
    - PING: no event strobe.
  - evt_dx, evt_dy and evt_wheel_val hold their last values between strobes.
- Response queueing:
  - PING queues PONG.
  - Other valid commands queue ACK when ACK_EN = 1.
- Timeout: a cycle counter runs in P_CMD and P_PAYLOAD and clears on every rx_valid.
  - On reaching TIMEOUT_CLKS: return to P_SYNC, err_count+1, no response, no event.
  - rx_valid arriving in the same cycle as the timeout: the byte wins and the counter clears.
- Pending response slot (1 entry: hdr, cmd):
  - Queuing while the slot is full overwrites the slot; drop_count+1, saturating.
  - Queuing in the same cycle the FSM takes the slot: the FSM takes the old entry and the new entry fills the slot; no drop.
- Response FSM:
  - R_IDLE -> R_SEND when the slot is full. On that transition, take the slot and snapshot the 8 bytes: [hdr, cmd, btn_state, pkt_count lo, pkt_count hi, err_count lo, err_count hi, VERSION]. Counter and btn_state values are those after the triggering packet's updates.
  - The first byte is on tx_data with tx_valid = 1 the cycle after the transition.
  - In R_SEND, tx_data/tx_valid hold until tx_valid && tx_ready; the next byte is presented the following cycle, i.e. back-to-back streaming at 1 byte per cycle is allowed.
  - After byte 7 is accepted, tx_valid drops and the FSM returns to R_IDLE.
  - Parsing continues during R_SEND.
- Counter wraparound: pkt_count and err_count wrap 16'hFFFF -> 0.

Test Plan:
- MOVE, tx_ready = 1: AA 01 34 12 CC FF -> one evt_move, evt_dx = 16'sh1234, evt_dy = -52. Response 0C 01 00 01 00 00 00 01 on consecutive cycles.
- Button state: AA 03 05 05 then AA 03 01 00 -> btn_state 8'h05 then 8'h04, two evt_btn pulses, no errors.
- PING with tx_ready toggling every other cycle -> PONG A0 05 …, each byte held stable until accepted, exactly 8 accepts.
- Unknown cmd: AA 7F -> err_count = 1, NACK 0E 7F …, no event. Then AA 02 FB -> evt_wheel with evt_wheel_val = -5.
- Truncated packet: AA 01 34 then idle TIMEOUT_CLKS cycles -> err_count+1, parser back in P_SYNC. A following AA 05 is PONGed normally.
- Overwrite: with tx_ready = 0, send three PINGs back-to-back -> drop_count = 1, exactly 2 PONGs once tx_ready = 1. Asserting rst_n low mid-response -> tx_valid = 0 and all counters 0 in the same cycle.
